// File: rtl/v_data_rd_arbiter.sv
// rtl/v_data_rd_arbiter.sv - round-robin arbiter sharing one DDR read channel among NUM_REQ requesters
module v_data_rd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic [NUM_REQ*32-1:0] req_addr_i,
    input  logic [NUM_REQ*32-1:0] req_size_i,
    output logic [DATA_W-1:0]    rsp_data_o,
    output logic [NUM_REQ-1:0]   rsp_valid_o,
    output logic                 rsp_last_o,
    input  logic [NUM_REQ-1:0]   rsp_ready_i,
    output logic [NUM_REQ-1:0]   done_o,
    output logic                 err_o,
    output logic [31:0]          ctrl_raddr_offset_o,
    output logic [31:0]          ctrl_rxfer_size_o,
    output logic                 ctrl_rstart_o,
    input  logic [DATA_W-1:0]    rd_tdata_i,
    input  logic                 rd_tvalid_i,
    input  logic                 rd_tlast_i,
    output logic                 rd_tready_o,
    input  logic                 ctrl_rdone_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        XFER,
        WAIT_DONE,
        DONE
    } state_t;

    state_t             state;
    // rr_next is the first index searched; it holds (last granted + 1), so a
    // reset value of 0 gives index 0 first priority after reset.
    logic [IDX_W-1:0]   rr_next;
    logic [IDX_W-1:0]   owner;
    logic [31:0]        beat_cnt;
    logic               rdone_seen;

    logic               grant_any;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [NUM_REQ-1:0] owner_oh;
    logic [31:0]        sel_addr;
    logic [31:0]        sel_size;
    logic               in_xfer;
    logic               beat_drop;
    logic               beat_acc;

    // Round-robin search starting at rr_next, wrapping past the top index
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_next) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any && req_valid_i[IDX_W'(idx)]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
    end

    // One-hot decodes and selection of the candidate's address and size
    always_comb begin
        grant_oh = '0;
        owner_oh = '0;
        sel_addr = '0;
        sel_size = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_oh[i] = (IDX_W'(i) == grant_idx);
            owner_oh[i] = (IDX_W'(i) == owner);
            if (IDX_W'(i) == grant_idx) begin
                sel_addr = req_addr_i[i*32 +: 32];
                sel_size = req_size_i[i*32 +: 32];
            end
        end
    end

    // Stream pass-through during XFER; beats past the expected count are swallowed
    always_comb begin
        in_xfer     = (state == XFER);
        beat_drop   = in_xfer && (beat_cnt == 32'd0);
        rd_tready_o = in_xfer && (beat_drop || rsp_ready_i[owner]);
        beat_acc    = rd_tvalid_i && rd_tready_o;
        rsp_valid_o = (in_xfer && rd_tvalid_i && !beat_drop) ? owner_oh : '0;
        rsp_data_o  = in_xfer ? rd_tdata_i : '0;
        rsp_last_o  = in_xfer && rd_tlast_i;
        // Gated by rstn so no grant leaks out while reset is held
        req_ready_o = (rstn && (state == IDLE) && grant_any) ? grant_oh : '0;
    end

    // Arbitration / transfer sequencing FSM with registered command and status outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state               <= IDLE;
            rr_next             <= '0;
            owner               <= '0;
            beat_cnt            <= '0;
            rdone_seen          <= 1'b0;
            err_o               <= 1'b0;
            done_o              <= '0;
            ctrl_rstart_o       <= 1'b0;
            ctrl_raddr_offset_o <= '0;
            ctrl_rxfer_size_o   <= '0;
        end else begin
            done_o        <= '0;
            ctrl_rstart_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner      <= grant_idx;
                        beat_cnt   <= {2'b00, sel_size[31:2]};
                        rdone_seen <= 1'b0;
                        if (sel_size[1:0] != 2'b00) begin
                            err_o <= 1'b1;
                        end
                        if (sel_size == 32'd0) begin
                            state  <= DONE;
                            done_o <= grant_oh;
                        end else begin
                            state               <= START;
                            ctrl_rstart_o       <= 1'b1;
                            ctrl_raddr_offset_o <= sel_addr;
                            ctrl_rxfer_size_o   <= sel_size;
                        end
                    end
                end
                START: begin
                    state <= XFER;
                    if (ctrl_rdone_i) begin
                        rdone_seen <= 1'b1;
                    end
                end
                XFER: begin
                    if (beat_acc) begin
                        if (beat_cnt == 32'd0) begin
                            err_o <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt - 32'd1;
                        end
                        if (rd_tlast_i && (beat_cnt != 32'd1)) begin
                            err_o <= 1'b1;
                        end
                    end
                    if (beat_acc && rd_tlast_i) begin
                        if (ctrl_rdone_i || rdone_seen) begin
                            state               <= DONE;
                            done_o              <= owner_oh;
                            ctrl_raddr_offset_o <= '0;
                            ctrl_rxfer_size_o   <= '0;
                        end else begin
                            state <= WAIT_DONE;
                        end
                    end else if (ctrl_rdone_i) begin
                        rdone_seen <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (ctrl_rdone_i) begin
                        state               <= DONE;
                        done_o              <= owner_oh;
                        ctrl_raddr_offset_o <= '0;
                        ctrl_rxfer_size_o   <= '0;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    rr_next <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
